// File: rtl/add32_sched_pkg.sv
// Shared types and constants for the round-robin scheduled 32-bit adder.
// Pipeline stage records are packed so they can be cleared and compared as single vectors.
package add32_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DATA_W    = 32;
    localparam int ID_W      = $clog2(N_REQ_DEF);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        req_id_t           id;
        logic              valid;
    } p0_t;

    typedef struct packed {
        logic [DATA_W-1:0] c;
        req_id_t           id;
        logic              valid;
    } p1_t;

endpackage

// File: rtl/add32.sv
// The existing combinational 32-bit adder; the carry-out is intentionally discarded.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    assign c = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer policy is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    int              pos;
    logic [ID_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop can infer a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = ID_W'(pos);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/add32_rr_scheduler.sv
// Shares one add32 among N_REQ valid/ready requesters through a 2-stage pipeline
// (operand register -> add32 -> result register) with round-robin admission.
module add32_rr_scheduler
    import add32_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_c,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy
);

    // The tag width comes from the package, so N_REQ must fit in it.
    if (N_REQ < 2 || N_REQ > (1 << ID_W)) begin : g_bad_n_req
        $error("add32_rr_scheduler: N_REQ=%0d does not fit ID_W=%0d", N_REQ, ID_W);
    end

    p0_t               p0;
    p1_t               p1;
    req_id_t           rr_ptr;

    logic [N_REQ-1:0]  grant;
    req_id_t           grant_idx;
    logic              any_req;
    logic              advance;
    logic              handshake;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] sum_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    add32 u_add32 (
        .a (p0.a),
        .b (p0.b),
        .c (sum_c)
    );

    // The whole pipe moves together; a stalled result freezes both stages.
    assign advance   = !p1.valid || rsp_ready;
    assign handshake = any_req && advance;
    assign req_ready = grant & {N_REQ{advance && rst_n}};

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data and tag fields are cleared too, so rsp_c/rsp_id read 0 out of reset.
            p0     <= '0;
            p1     <= '0;
            rr_ptr <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let p1 capture the old p0 while p0 reloads.
            p1 <= '{c: sum_c, id: p0.id, valid: p0.valid};
            p0 <= '{a: sel_a, b: sel_b, id: grant_idx, valid: handshake};
            if (handshake) begin
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign rsp_valid = p1.valid;
    assign rsp_c     = p1.c;
    assign rsp_id    = p1.id;
    assign busy      = p0.valid || p1.valid;

endmodule

// File: tb/tb_add32_rr_scheduler.sv
// Scoreboard bench for add32_rr_scheduler: accepted requests push a + b into a queue,
// a monitor checks ready, occupancy and every presented response against that queue.
module tb_add32_rr_scheduler;
    import add32_sched_pkg::*;

    localparam int N = N_REQ_DEF;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N*DATA_W-1:0] req_a;
    logic [N*DATA_W-1:0] req_b;
    logic [N-1:0]        req_ready;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_c;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_ready;
    logic                busy;

    add32_rr_scheduler #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] c;
        int                id;
    } rsp_t;

    // Reference model: in-flight results in order, plus which of the two slots hold one.
    rsp_t              exp_q[$];
    bit                m0_v, m1_v;
    int                model_ptr;
    logic [N-1:0]      accepted;

    // Monitor scratch and requester-stability history.
    bit                adv;
    int                g;
    logic [N-1:0]      exp_rdy;
    rsp_t              item;
    logic [N-1:0]      prev_valid, prev_acc;
    logic [DATA_W-1:0] prev_a [N];
    logic [DATA_W-1:0] prev_b [N];

    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_req_ready", req_ready, 0);
            exp_q.delete();
            m0_v       = 1'b0;
            m1_v       = 1'b0;
            model_ptr  = 0;
            accepted   = '0;
            prev_valid = '0;
            prev_acc   = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (prev_valid[i] && !prev_acc[i]) begin
                    assert (req_valid[i] && req_a[i*DATA_W +: DATA_W] == prev_a[i]
                            && req_b[i*DATA_W +: DATA_W] == prev_b[i])
                    else $error("requester %0d changed its request before handshake", i);
                end
            end

            adv = !m1_v || rsp_ready;
            g   = -1;
            for (int off = 0; off < N; off++) begin
                if (g < 0 && req_valid[(model_ptr + off) % N]) g = (model_ptr + off) % N;
            end
            exp_rdy = '0;
            if (adv && g >= 0) exp_rdy[g] = 1'b1;

            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, m1_v);
            check("busy", busy, m0_v || m1_v);
            if (m1_v) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    check("rsp_c", rsp_c, exp_q[0].c);
                    check("rsp_id", rsp_id, exp_q[0].id);
                end
            end

            accepted   = req_valid & req_ready;
            prev_valid = req_valid;
            prev_acc   = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                prev_a[i] = req_a[i*DATA_W +: DATA_W];
                prev_b[i] = req_b[i*DATA_W +: DATA_W];
            end

            if (adv) begin
                if (m1_v && exp_q.size() > 0) void'(exp_q.pop_front());
                m1_v = m0_v;
                m0_v = (g >= 0);
                if (g >= 0) begin
                    item.c  = req_a[g*DATA_W +: DATA_W] + req_b[g*DATA_W +: DATA_W];
                    item.id = g;
                    exp_q.push_back(item);
                    model_ptr = (g + 1) % N;
                end
            end
        end
    end

    // Requester state: a request stays posted until the monitor sees it accepted.
    logic [N-1:0]      cur_valid;
    logic [DATA_W-1:0] cur_a [N];
    logic [DATA_W-1:0] cur_b [N];

    function automatic logic [DATA_W-1:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic post(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (!cur_valid[i]) begin
            cur_valid[i] = 1'b1;
            cur_a[i]     = a;
            cur_b[i]     = b;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]               = cur_valid[i];
            req_a[i*DATA_W +: DATA_W] = cur_valid[i] ? cur_a[i] : '0;
            req_b[i*DATA_W +: DATA_W] = cur_valid[i] ? cur_b[i] : '0;
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cur_valid = cur_valid & ~accepted;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            drive();
        end
    endtask

    task automatic serve(input string name, input int max_cycles);
        int k = 0;
        do begin
            next_cycle();
            drive();
            k++;
        end while (cur_valid != '0 && k < max_cycles);
        check(name, cur_valid, 0);
    endtask

    task automatic post_all();
        for (int i = 0; i < N; i++) post(i, rand_op(), rand_op());
    endtask

    task automatic pulse_reset();
        next_cycle();
        #1 rst_n = 1'b0;
        #1;
        check("reset_rsp_valid_now", rsp_valid, 0);
        check("reset_busy_now", busy, 0);
        cur_valid = '0;
        drive();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        cur_valid = '0;
        accepted  = '0;
        drive();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single request, then a carry-dropping sum from requester 1.
        rsp_ready = 1'b1;
        post(0, 32'd5, 32'd7);
        serve("t1_accept", 4);
        idle(3);
        post(1, 32'hFFFF_FFFF, 32'd2);
        serve("t2_accept", 4);
        idle(3);

        // All requesters continuously valid from a fresh pointer.
        pulse_reset();
        repeat (6) begin
            next_cycle();
            post_all();
            drive();
        end

        // Fill the pipe and hold the response port off, then drain.
        rsp_ready = 1'b0;
        repeat (5) begin
            next_cycle();
            post_all();
            drive();
        end
        rsp_ready = 1'b1;
        serve("t4_drain", 20);
        idle(3);

        // Wrap-around search: after req3 the pointer is 0, then req2, then req0 beats req2.
        post(3, 32'd30, 32'd3);
        serve("t5_req3", 4);
        post(2, 32'd20, 32'd2);
        serve("t5_req2", 4);
        post(0, 32'd1, 32'd1);
        post(2, 32'd2, 32'd2);
        serve("t5_req0_req2", 6);
        idle(3);

        // Reset with results in flight, then lowest valid index wins from pointer 0.
        repeat (2) begin
            next_cycle();
            post_all();
            drive();
        end
        pulse_reset();
        post(3, 32'd33, 32'd3);
        post(1, 32'd11, 32'd1);
        serve("t6_after_reset", 6);
        idle(3);

        // Random traffic with random back-pressure.
        repeat (600) begin
            next_cycle();
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1) == 1) post(i, rand_op(), rand_op());
            end
            drive();
        end

        rsp_ready = 1'b1;
        serve("final_drain", 40);
        idle(4);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
